// File: rtl/p_div_pow2_pipe.sv
// Per-lane signed/unsigned divide by 2^shamt with floor/round-half-up/ceil, then clamp to the output format.
// Latency 2 cycles, 1 transfer/cycle; the whole pipe stalls when out_valid && !out_ready.
// Optional P_DIV_POW2_PIPE_STATS_EN adds sat_cnt, a count of output transfers with any lane saturated.
package p_div_pow2_pipe_pkg;
   typedef enum logic [1:0] {INT = 2'd0, FIXED = 2'd1} dtype_e;
   typedef struct packed {
      dtype_e     dtype;
      logic       sign;
      logic [7:0] prec;
      logic [7:0] frac;
   } dconf_t;
endpackage

module p_div_pow2_pipe
   import p_div_pow2_pipe_pkg::*;
#(
   parameter int     LANES     = 4,
   parameter dconf_t I_CONF    = '{dtype: INT, sign: 1'b1, prec: 8'd8, frac: 8'd0},
   parameter dconf_t O_CONF    = '{dtype: INT, sign: 1'b1, prec: 8'd8, frac: 8'd0},
   parameter int     MAX_SHIFT = 7,
   localparam int    I_PREC    = int'(I_CONF.prec),
   localparam int    O_PREC    = int'(O_CONF.prec),
   localparam int    SHW       = $clog2(MAX_SHIFT + 1)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [LANES*I_PREC-1:0]      in_data,
   input  logic [SHW-1:0]               in_shamt,
   input  logic [1:0]                   in_mode,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [LANES*O_PREC-1:0]      out_data,
   output logic [LANES*MAX_SHIFT-1:0]   out_rem,
   output logic [LANES-1:0]             out_sat
`ifdef P_DIV_POW2_PIPE_STATS_EN
   ,
   output logic [15:0]                  sat_cnt
`endif
);

   localparam int FD   = int'(I_CONF.frac) - int'(O_CONF.frac);
   localparam int SMAX = MAX_SHIFT + FD;
   localparam int XW   = I_PREC + SMAX + 1;
   localparam int QW   = I_PREC + 1;
   localparam int CW   = ((QW > O_PREC + 1) ? QW : O_PREC + 1) + 1;

   localparam logic [XW-1:0]        ONE_X = XW'(1);
   localparam logic signed [CW-1:0] ONE_C = CW'(1);
   localparam logic signed [CW-1:0] OMAX  = O_CONF.sign ? (ONE_C <<< (O_PREC - 1)) - ONE_C
                                                        : (ONE_C <<< O_PREC) - ONE_C;
   localparam logic signed [CW-1:0] OMIN  = O_CONF.sign ? -(ONE_C <<< (O_PREC - 1)) : '0;

   if (I_CONF.dtype != O_CONF.dtype || I_CONF.frac < O_CONF.frac) begin : g_conf_err
      $error("p_div_pow2_pipe: I_CONF/O_CONF dtype mismatch or output has more fraction bits");
   end

   logic s1_valid;

   assign in_ready = !out_valid || out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid  <= 1'b0;
         out_valid <= 1'b0;
      end else if (in_ready) begin
         s1_valid  <= in_valid;
         out_valid <= s1_valid;
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [I_PREC-1:0]      lane_in;
      logic                   sbit;
      logic signed [XW-1:0]   ext;
      logic [XW-1:0]          drop;
      logic signed [QW-1:0]   q_n;
      logic signed [QW-1:0]   q1;
      logic                   half;
      logic                   inc_n;
      logic                   inc1;
      logic [MAX_SHIFT-1:0]   rem1;
      logic [MAX_SHIFT-1:0]   rem2;
      logic signed [CW-1:0]   r;
      logic                   sat_hi;
      logic                   sat_lo;
      logic                   sat2;
      logic [O_PREC-1:0]      dat2;
      int                     eff;

      assign lane_in = in_data[l*I_PREC +: I_PREC];
      assign sbit    = I_CONF.sign & lane_in[I_PREC-1];

      // Unsigned lanes get a zero top bit, so one arithmetic shift covers both formats.
      always_comb begin
         ext   = {{(XW-I_PREC){sbit}}, lane_in};
         eff   = int'(in_shamt) + FD;
         drop  = ext & ((ONE_X << eff) - ONE_X);
         half  = (eff > 0) ? |(drop & (ONE_X << (eff - 1))) : 1'b0;
         q_n   = QW'(ext >>> eff);
         case (in_mode)
            2'd1:    inc_n = half;
            2'd2:    inc_n = |drop;
            default: inc_n = 1'b0;
         endcase
      end

      assign r      = CW'(q1) + CW'($signed({1'b0, inc1}));
      assign sat_hi = (r > OMAX);
      assign sat_lo = (r < OMIN);

      always_ff @(posedge clk) begin
         if (reset) begin
            q1   <= '0;
            inc1 <= 1'b0;
            rem1 <= '0;
            dat2 <= '0;
            rem2 <= '0;
            sat2 <= 1'b0;
         end else if (in_ready) begin
            q1   <= q_n;
            inc1 <= inc_n;
            rem1 <= drop[MAX_SHIFT-1:0];
            dat2 <= sat_hi ? OMAX[O_PREC-1:0] : (sat_lo ? OMIN[O_PREC-1:0] : r[O_PREC-1:0]);
            rem2 <= rem1;
            sat2 <= sat_hi | sat_lo;
         end
      end

      assign out_data[l*O_PREC +: O_PREC]       = dat2;
      assign out_rem[l*MAX_SHIFT +: MAX_SHIFT] = rem2;
      assign out_sat[l]                        = sat2;
   end

`ifdef P_DIV_POW2_PIPE_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         sat_cnt <= '0;
      end else if (out_valid && out_ready && (|out_sat) && (sat_cnt != 16'hFFFF)) begin
         sat_cnt <= sat_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_p_div_pow2_pipe.sv
// Bench for p_div_pow2_pipe: default 8->8 instance plus an 8->4 instance sharing the same stimulus.
module tb_p_div_pow2_pipe;
   import p_div_pow2_pipe_pkg::*;

   localparam dconf_t C8 = '{dtype: INT, sign: 1'b1, prec: 8'd8, frac: 8'd0};
   localparam dconf_t C4 = '{dtype: INT, sign: 1'b1, prec: 8'd4, frac: 8'd0};

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] in_data;
   logic [2:0]  in_shamt;
   logic [1:0]  in_mode;
   logic        in_ready, out_valid, in_ready4, out_valid4;
   logic [31:0] out_data;
   logic [27:0] out_rem, out_rem4;
   logic [3:0]  out_sat, out_sat4;
   logic [15:0] out_data4;
`ifdef P_DIV_POW2_PIPE_STATS_EN
   logic [15:0] sat_cnt, sat_cnt4;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   p_div_pow2_pipe #(.LANES(4), .I_CONF(C8), .O_CONF(C8), .MAX_SHIFT(7)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_rem(out_rem), .out_sat(out_sat)
`ifdef P_DIV_POW2_PIPE_STATS_EN
      , .sat_cnt(sat_cnt)
`endif
   );

   p_div_pow2_pipe #(.LANES(4), .I_CONF(C8), .O_CONF(C4), .MAX_SHIFT(7)) dut4 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
      .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
      .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
      .out_rem(out_rem4), .out_sat(out_sat4)
`ifdef P_DIV_POW2_PIPE_STATS_EN
      , .sat_cnt(sat_cnt4)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: integer floor via positive modulo, then round/ceil increment, then clamp.
   function automatic void model(input logic [31:0] din, input int s, input int mode, input int oprec,
                                 output logic [31:0] dat, output logic [27:0] rem, output logic [3:0] sat);
      int v, p, r, q, omax, omin;
      dat = '0;
      rem = '0;
      sat = '0;
      for (int l = 0; l < 4; l++) begin
         v = int'($signed(din[l*8 +: 8]));
         p = 1 << s;
         r = ((v % p) + p) % p;
         q = (v - r) / p;
         if (s > 0 && mode == 1 && 2 * r >= p) q++;
         if (s > 0 && mode == 2 && r != 0) q++;
         omax = (1 << (oprec - 1)) - 1;
         omin = -(1 << (oprec - 1));
         if (q > omax) begin q = omax; sat[l] = 1'b1; end
         else if (q < omin) begin q = omin; sat[l] = 1'b1; end
         rem[l*7 +: 7] = 7'(r);
         for (int b = 0; b < oprec; b++) dat[l*oprec + b] = q[b];
      end
   endfunction

   task automatic send1(input logic [31:0] d, input logic [2:0] s, input logic [1:0] m);
      in_data   = d;
      in_shamt  = s;
      in_mode   = m;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      check("acc_ready", in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("lat1_valid", out_valid, 0);
      @(posedge clk);
      @(negedge clk);
      check("lat2_valid", out_valid, 1);
   endtask

   typedef struct {
      logic [31:0] d1;
      logic [27:0] rem;
      logic [3:0]  s1;
      logic [31:0] d2;
      logic [3:0]  s2;
   } exp_t;

   initial begin
      #1000000;
      $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   initial begin
      exp_t        sb[$];
      exp_t        e;
      logic [27:0] r2;
      int          acc;
      int          cyc;
      bit          hold;

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      in_data = '0; in_shamt = '0; in_mode = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_rem", out_rem, 0);
      check("rst_sat", out_sat, 0);
      check("rst_ready", in_ready, 1);

      // lanes 03, FE, 7F, 80; shift 2, round-half-up
      send1(32'h807F_FE03, 3'd2, 2'd1);
      check("rhu_data", out_data, 32'hE020_0001);
      check("rhu_rem", out_rem, 28'h000_C103);
      check("rhu_sat", out_sat, 4'b0000);
      check("rhu_data4", out_data4, 16'h8701);
      check("rhu_sat4", out_sat4, 4'b1100);

      send1(32'hFEFE_FEFE, 3'd2, 2'd0);
      check("neg_floor", out_data, 32'hFFFF_FFFF);
      check("neg_floor_rem", out_rem, 28'h040_8102);
      send1(32'hFEFE_FEFE, 3'd2, 2'd1);
      check("neg_round", out_data, 32'h0000_0000);
      send1(32'hFEFE_FEFE, 3'd2, 2'd2);
      check("neg_ceil", out_data, 32'h0000_0000);
      check("neg_ceil_sat4", out_sat4, 4'b0000);

      send1(32'h7F7F_7F7F, 3'd1, 2'd0);
      check("max_data", out_data, 32'h3F3F_3F3F);
      check("max_rem", out_rem, 28'h020_4081);
      check("max_data4", out_data4, 16'h7777);
      check("max_sat4", out_sat4, 4'hF);
      send1(32'h8080_8080, 3'd1, 2'd0);
      check("min_data", out_data, 32'hC0C0_C0C0);
      check("min_data4", out_data4, 16'h8888);
      check("min_sat4", out_sat4, 4'hF);
      @(posedge clk);
      @(negedge clk);
`ifdef P_DIV_POW2_PIPE_STATS_EN
      check("sat_cnt4", sat_cnt4, 16'd3);
      check("sat_cnt8", sat_cnt, 16'd0);
`endif

      // back-to-back 10,20,30 with a 3-cycle stall once the first result appears
      in_valid = 1'b1; in_shamt = 3'd1; in_mode = 2'd0; out_ready = 1'b1;
      in_data = 32'h0A0A_0A0A;
      @(posedge clk); @(negedge clk);
      in_data = 32'h1414_1414;
      @(posedge clk); @(negedge clk);
      in_data = 32'h1E1E_1E1E;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall_valid", out_valid, 1);
         check("stall_data", out_data, 32'h0505_0505);
         check("stall_ready", in_ready, 0);
         @(posedge clk); @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      check("resume_ready", in_ready, 1);
      check("resume_data", out_data, 32'h0505_0505);
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      check("stream_v2", out_valid, 1);
      check("stream_d2", out_data, 32'h0A0A_0A0A);
      @(posedge clk); @(negedge clk);
      check("stream_v3", out_valid, 1);
      check("stream_d3", out_data, 32'h0F0F_0F0F);
      @(posedge clk); @(negedge clk);
      check("stream_end", out_valid, 0);

      // reset with two transfers in flight during a stall
      in_valid = 1'b1; in_data = 32'h0A0A_0A0A;
      @(posedge clk); @(negedge clk);
      in_data = 32'h1414_1414;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0; reset = 1'b1;
      @(posedge clk); @(negedge clk);
      reset = 1'b0;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_data", out_data, 0);
      check("mid_rst_ready", in_ready, 1);
      @(posedge clk); @(negedge clk);
      check("mid_rst_stale1", out_valid, 0);
      @(posedge clk); @(negedge clk);
      check("mid_rst_stale2", out_valid, 0);
      send1(32'h6464_6464, 3'd2, 2'd2);
      check("post_rst_data", out_data, 32'h1919_1919);
      check("post_rst_rem", out_rem, 28'h0);
      check("post_rst_data4", out_data4, 16'h7777);

      // random transfers against the reference model
      acc = 0; cyc = 0; hold = 1'b0;
      while ((acc < 1000 || sb.size() != 0) && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (!hold) begin
            if (acc < 1000 && $urandom_range(3) != 0) begin
               in_valid = 1'b1;
               in_data  = $urandom;
               in_shamt = 3'($urandom_range(7));
               in_mode  = 2'($urandom_range(3));
            end else begin
               in_valid = 1'b0;
            end
         end
         out_ready = ($urandom_range(3) != 0);
         #1;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("rnd_spurious", out_valid, 0);
            end else begin
               e = sb.pop_front();
               check("rnd_data", out_data, e.d1);
               check("rnd_rem", out_rem, e.rem);
               check("rnd_sat", out_sat, e.s1);
               check("rnd_data4", out_data4, e.d2[15:0]);
               check("rnd_sat4", out_sat4, e.s2);
            end
         end
         if (in_valid && in_ready) begin
            model(in_data, int'(in_shamt), int'(in_mode), 8, e.d1, e.rem, e.s1);
            model(in_data, int'(in_shamt), int'(in_mode), 4, e.d2, r2, e.s2);
            sb.push_back(e);
            acc++;
            hold = 1'b0;
         end else begin
            hold = in_valid;
         end
      end
      check("rnd_accepted", acc, 1000);
      check("rnd_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/p_div_pow2_pipe.md
P_DIV_POW2_PIPE -- requirements
Module: p_div_pow2_pipe

Interface
REQ-001 SHALL have parameter LANES, default 4: number of independent data lanes processed per transfer.
REQ-002 SHALL have parameter I_CONF (dconf_t), default {INT, sign:1, prec:8, frac:0}: input lane format.
REQ-003 SHALL have parameter O_CONF (dconf_t), default {INT, sign:1, prec:8, frac:0}: output lane format; I_CONF.dtype SHALL equal O_CONF.dtype and I_CONF.frac >= O_CONF.frac, else elaboration error.
REQ-004 SHALL have parameter MAX_SHIFT, default 7: largest runtime shift; SHW = $clog2(MAX_SHIFT+1).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1  input transfer request.
REQ-008 in_ready  out  1  block accepts input this cycle.
REQ-009 in_data  in  LANES*I_PREC  packed lane operands, lane 0 in LSBs.
REQ-010 in_shamt  in  SHW  divide by 2^in_shamt, shared by all lanes.
REQ-011 in_mode  in  2  rounding: 0 floor, 1 round-half-up, 2 ceil, 3 reserved (treated as 0).
REQ-012 out_valid  out  1  output transfer valid.
REQ-013 out_ready  in  1  downstream accepts output.
REQ-014 out_data  out  LANES*O_PREC  packed quotients.
REQ-015 out_rem  out  LANES*MAX_SHIFT  per-lane discarded low bits, zero-extended.
REQ-016 out_sat  out  LANES  per-lane saturation flag.

Function
REQ-017 Transfer occurs when valid and ready are both high on a clock edge; in_ready = !out_valid || out_ready (combinational, whole pipe stalls together).
REQ-018 Two pipeline stages: S1 registers arithmetic shift, dropped bits, round decision; S2 registers rounded, saturated result; latency exactly 2 cycles with out_ready high; throughput 1 transfer/cycle.
REQ-019 Effective right shift per lane = in_shamt + I_FRAC - O_FRAC; signed inputs shift arithmetically, unsigned logically.
REQ-020 Rounding increment: mode 0 never; mode 1 when dropped bits >= 2^(in_shamt-1); mode 2 when dropped bits nonzero; in_shamt = 0 -> no increment, out_rem = 0.
REQ-021 Rounded value SHALL be computed one bit wider than I_PREC; no internal overflow.
REQ-022 Result outside O_CONF range SHALL clamp to O max/min and set that lane's out_sat; otherwise out_sat = 0.
REQ-023 While out_valid && !out_ready, out_data/out_rem/out_sat SHALL hold stable and no input is accepted.
REQ-024 Bubbles (in_valid low while advancing) SHALL propagate as out_valid low; no data duplicated or lost.

Reset
REQ-025 On reset: out_valid = 0, S1 valid = 0, out_data/out_rem/out_sat = 0; in-flight transfers discarded; in_ready = 1 the cycle after reset deasserts.
REQ-026 Reset asserted mid-stall SHALL win over hold; no output transfer reported in the reset cycle.

Configuration
REQ-027 Macro P_DIV_POW2_PIPE_STATS_EN SHALL, when defined, add output sat_cnt [16]: count of output transfers with any out_sat bit set, saturating at 16'hFFFF, cleared by reset.
REQ-028 Without P_DIV_POW2_PIPE_STATS_EN, sat_cnt port and counter logic SHALL be absent; all other behaviour identical.

Verification (defaults, lane 0 shown)
REQ-029 in=3, shamt=2, mode=1 -> out=1, rem=3, sat=0, out_valid exactly 2 cycles after accept.
REQ-030 in=-2 (8'hFE), shamt=2: mode 0 -> out=-1, rem=2; mode 1 -> out=0; mode 2 -> out=0.
REQ-031 O_PREC=4 signed, in=127, shamt=1, mode 0 -> out=7, sat=1; in=-128 -> out=-8, sat=1; with macro sat_cnt=2.
REQ-032 Back-to-back inputs 10,20,30 (shamt=1, mode 0), out_ready low 3 cycles mid-stream -> in_ready low while stalled, outputs 5,10,15 in order, held stable during stall.
REQ-033 Reset pulsed while 2 transfers in flight -> out_valid=0 next cycle, no stale data emitted; fresh input after reset produces correct result.
REQ-034 Random LOOP=1000 transfers, all modes/shifts, random out_ready -> every lane matches software model (floor/round/ceil then clamp).
